seg7_frame_decoder: RTL and testbench
=====================================

# seg7_frame_decoder

Inverse of the board's hex-digit display path: accepts active-low seven-segment patterns one digit at a time over a valid/ready handshake, decodes each back to its 4-bit hex nibble, and assembles DIGITS nibbles into one packed value. The block is used wherever a captured display stream needs to be checked or re-used as a number, such as a loopback self-check of the counter/display lab hardware. Patterns that do not match a hex glyph are flagged per frame.

## Interface
- DIGITS, default 4: digits per frame; legal range 1..8.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- seg_in  in  7  active-low segment pattern; bit 6 = g … bit 0 = a.
- seg_valid  in  1  seg_in holds a digit.
- seg_ready  out  1  block can accept a digit this cycle.
- value  out  4*DIGITS  last completed frame; the first digit received is the least-significant nibble.
- value_valid  out  1  value holds a completed frame not yet consumed.
- value_ready  in  1  consumer accepts value.
- digit_err  out  1  at least one digit in the presented frame was invalid; qualified by value_valid.

## Operation
- Decode table (pattern→nibble): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
- Any other pattern is invalid. It decodes to nibble 0 and sets the frame error flag.
- State machine:
  - COLLECT: seg_ready=1. On each accept (seg_valid & seg_ready), the decoded nibble is written into shadow[idx*4 +: 4], the error bit is ORed into a shadow error bit, and idx increments.
  - Accept with idx==DIGITS-1: shadow plus the current nibble is copied to value, the error is copied to digit_err, and the block goes to PRESENT. idx and the shadow error are cleared.
  - PRESENT: seg_ready=0 and value_valid=1. On value_ready=1 the block returns to COLLECT. value and digit_err keep their contents.
- idx width is clog2(DIGITS), minimum 1. idx never exceeds DIGITS-1; it wraps to 0 only on frame completion or reset.
- seg_in is ignored when seg_valid=0 or seg_ready=0.
- value changes only on frame completion or reset. Partial frames are never visible.

## Timing
- Reset values: state=COLLECT, idx=0, shadow=0, value=0, value_valid=0, digit_err=0. seg_ready reads 1 in the first cycle after reset deasserts.
- While reset=1, no digit is accepted and no handshake completes.
- seg_ready and value_valid are decoded directly from the state register, with no combinational path from any input.
- Latency: value and value_valid update on the clock edge that accepts the final digit, so they are visible the next cycle.
- Throughput: at most one digit per cycle. With value_ready held at 1, a frame takes DIGITS+1 cycles (DIGITS accepts plus one PRESENT cycle).
- Backpressure: value_ready=0 holds PRESENT indefinitely. seg_ready stays 0 and no digits are lost, because the producer holds its data.
- Reset mid-frame: the partial frame is discarded and value is cleared to 0. The next accepted digit is digit 0.
- Reset during PRESENT: the undelivered frame is dropped and value_valid becomes 0.

## Configuration
- SEG7_BLANK_ZERO_EN defined: the all-off pattern 1111111 decodes to nibble 0 and is valid, which supports leading-blank suppression.
- SEG7_BLANK_ZERO_EN undefined: 1111111 is invalid. It decodes to 0 and sets digit_err for the frame.

## Test plan
- Reset, then send 1111001, 0100100, 0110000, 0011001 on consecutive cycles with value_ready=1 → value=16'h4321, value_valid=1 for exactly one cycle, digit_err=0.
- Complete a frame with value_ready=0 for 5 cycles while seg_valid=1 → seg_ready=0 for all 5 cycles, value stays stable. Raise value_ready → the next frame starts accepting on the following cycle with no digit dropped.
- Send digits 0,1,1111110,F → value=16'hF010 and digit_err=1. The next frame, containing only valid digits 8,8,8,8 → value=16'h8888 and digit_err=0.
- Send 1111111 as digit 3 after 1,2,3 → value=16'h0321 in both builds. digit_err=0 with SEG7_BLANK_ZERO_EN defined and 1 without it.
- Send 2 digits, then assert reset for 1 cycle, then send A, b, C, d → value=0 immediately after reset, then value=16'hDCBA with no contamination from the earlier partial digits.
- Stream 3 frames with seg_valid and value_ready tied to 1 → value_valid pulses every 5 cycles and each value matches its frame.

Source files
------------

// File: rtl/seg7_frame_decoder.sv
// rtl/seg7_frame_decoder.sv - active-low 7-segment digit stream to packed hex frame decoder
// Optional feature macro: SEG7_BLANK_ZERO_EN (all-off glyph decodes as a valid 0).
module seg7_frame_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic                  digit_err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic                 err_q, err_d;
    logic [4*DIGITS-1:0]  value_q, value_d;
    logic                 digit_err_q, digit_err_d;

    logic [3:0]           nib;
    logic                 bad;
    logic                 accept;
    logic                 last_digit;
    logic [4*DIGITS-1:0]  frame_word;

    always_comb begin
        nib = 4'h0;
        bad = 1'b0;
        case (seg_in)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
`ifdef SEG7_BLANK_ZERO_EN
            7'b1111111: nib = 4'h0;
`endif
            default:    bad = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last_digit) state_d = PRESENT;
            PRESENT: if (value_ready)          state_d = COLLECT;
            default:                           state_d = COLLECT;
        endcase
    end

    // Handshake outputs depend only on the state register, never on inputs.
    always_comb begin
        seg_ready   = (state_q == COLLECT);
        value_valid = (state_q == PRESENT);
    end

    assign accept     = seg_valid & seg_ready;
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
    assign value      = value_q;
    assign digit_err  = digit_err_q;

    always_comb begin
        frame_word = shadow_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) frame_word[i*4 +: 4] = nib;
        end
    end

    always_comb begin
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        err_d       = err_q;
        value_d     = value_q;
        digit_err_d = digit_err_q;
        if (accept) begin
            if (last_digit) begin
                value_d     = frame_word;
                digit_err_d = err_q | bad;
                shadow_d    = '0;
                err_d       = 1'b0;
                idx_d       = '0;
            end else begin
                shadow_d    = frame_word;
                err_d       = err_q | bad;
                idx_d       = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q       <= '0;
            shadow_q    <= '0;
            err_q       <= 1'b0;
            value_q     <= '0;
            digit_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            err_q       <= err_d;
            value_q     <= value_d;
            digit_err_q <= digit_err_d;
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb/tb_seg7_frame_decoder.sv - self-checking bench for seg7_frame_decoder
// Exercises both builds of SEG7_BLANK_ZERO_EN through the reference decode.
module tb_seg7_frame_decoder;

    localparam int DIGITS = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [6:0]           seg_in;
    logic                 seg_valid;
    logic                 seg_ready;
    logic [4*DIGITS-1:0]  value;
    logic                 value_valid;
    logic                 value_ready;
    logic                 digit_err;

    seg7_frame_decoder #(.DIGITS(DIGITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg_in      (seg_in),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .digit_err   (digit_err)
    );

    always #5 clock = ~clock;

    logic [6:0] glyph [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cycle = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Reference model: frame as a queue of decoded digits, packed when full.
    logic [3:0]           mq_nib [$];
    logic                 mq_err;
    logic [4*DIGITS-1:0]  exp_value;
    logic                 exp_valid;
    logic                 exp_err;
    logic                 model_live = 1'b0;

    function automatic logic [4:0] ref_decode(input logic [6:0] g);
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == g) return {1'b0, 4'(i)};
        end
`ifdef SEG7_BLANK_ZERO_EN
        if (g == 7'h7F) return 5'h00;
`endif
        return 5'h10;
    endfunction

    always @(posedge clock) begin
        cycle++;
        if (reset) begin
            mq_nib.delete();
            mq_err     = 1'b0;
            exp_value  = '0;
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (exp_valid) begin
                if (value_ready) exp_valid = 1'b0;
            end else if (seg_valid) begin
                logic [4:0] d;
                d = ref_decode(seg_in);
                mq_nib.push_back(d[3:0]);
                mq_err = mq_err | d[4];
                if (mq_nib.size() == DIGITS) begin
                    for (int i = 0; i < DIGITS; i++) exp_value[i*4 +: 4] = mq_nib[i];
                    exp_err   = mq_err;
                    exp_valid = 1'b1;
                    mq_nib.delete();
                    mq_err    = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("seg_ready",   32'(seg_ready),   32'(!exp_valid));
            check("value_valid", 32'(value_valid), 32'(exp_valid));
            check("value",       32'(value),       32'(exp_value));
            check("digit_err",   32'(digit_err),   32'(exp_err));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_digit(input logic [6:0] g);
        seg_in    = g;
        seg_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (seg_ready === 1'b1) begin
                @(negedge clock);
                return;
            end
            @(negedge clock);
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_frame(input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3);
        send_digit(g0);
        send_digit(g1);
        send_digit(g2);
        send_digit(g3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int unsigned t_prev;
    int unsigned t_now;

    initial begin
        reset       = 1'b1;
        seg_in      = 7'h7F;
        seg_valid   = 1'b0;
        value_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_value",       32'(value),       32'h0);
        check("rst_value_valid", 32'(value_valid), 32'h0);
        check("rst_digit_err",   32'(digit_err),   32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_seg_ready", 32'(seg_ready), 32'h1);

        // Basic frame, value_valid for exactly one cycle.
        send_frame(glyph[1], glyph[2], glyph[3], glyph[4]);
        seg_valid = 1'b0;
        check("t1_valid", 32'(value_valid), 32'h1);
        check("t1_value", 32'(value),       32'h4321);
        check("t1_err",   32'(digit_err),   32'h0);
        @(negedge clock);
        check("t1_valid_pulse", 32'(value_valid), 32'h0);

        // Backpressure: PRESENT held while the next digit waits.
        value_ready = 1'b0;
        send_frame(glyph[5], glyph[6], glyph[7], glyph[8]);
        seg_in    = glyph[9];
        seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_ready_low", 32'(seg_ready), 32'h0);
            check("t2_hold",      32'(value),     32'h8765);
            @(negedge clock);
        end
        value_ready = 1'b1;
        @(negedge clock);
        check("t2_ready_back", 32'(seg_ready), 32'h1);
        send_frame(glyph[9], glyph[10], glyph[11], glyph[12]);
        check("t2_next_value", 32'(value), 32'hCBA9);

        // Invalid glyph flags the frame; the following clean frame clears it.
        send_frame(glyph[0], glyph[1], 7'b1111110, glyph[15]);
        check("t3_value", 32'(value),     32'hF010);
        check("t3_err",   32'(digit_err), 32'h1);
        send_frame(glyph[8], glyph[8], glyph[8], glyph[8]);
        check("t3b_value", 32'(value),     32'h8888);
        check("t3b_err",   32'(digit_err), 32'h0);

        // Blank glyph as last digit.
        send_frame(glyph[1], glyph[2], glyph[3], 7'b1111111);
        check("t4_value", 32'(value), 32'h0321);
`ifdef SEG7_BLANK_ZERO_EN
        check("t4_err", 32'(digit_err), 32'h0);
`else
        check("t4_err", 32'(digit_err), 32'h1);
`endif

        // Reset mid-frame discards the partial digits.
        send_digit(glyph[5]);
        send_digit(glyph[6]);
        seg_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t5_value_rst", 32'(value),       32'h0);
        check("t5_valid_rst", 32'(value_valid), 32'h0);
        check("t5_ready_rst", 32'(seg_ready),   32'h1);
        send_frame(glyph[10], glyph[11], glyph[12], glyph[13]);
        check("t5_value", 32'(value),     32'hDCBA);
        check("t5_err",   32'(digit_err), 32'h0);

        // Streaming: a frame every DIGITS+1 cycles.
        send_frame(glyph[3], glyph[1], glyph[4], glyph[1]);
        t_prev = cycle;
        check("t6_f1", 32'(value), 32'h1413);
        send_frame(glyph[5], glyph[9], glyph[2], glyph[6]);
        t_now = cycle;
        check("t6_f2",     32'(value),      32'h6295);
        check("t6_period", t_now - t_prev,  32'd5);
        t_prev = t_now;
        send_frame(glyph[14], glyph[0], glyph[7], glyph[15]);
        t_now = cycle;
        check("t6_f3",      32'(value),     32'hF70E);
        check("t6_period2", t_now - t_prev, 32'd5);
        seg_valid = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
